// File: rtl/dice_lights_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dice_lights_pkg
// Description : Light state enum, {red,amber,green} encodings and a timer-width
//               helper shared by the dice/lights output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package dice_lights_pkg;

    typedef enum logic [1:0] {
        ST_RED       = 2'd0,
        ST_RED_AMBER = 2'd1,
        ST_GREEN     = 2'd2,
        ST_AMBER     = 2'd3
    } light_state_e;

    // Bit order is {red, amber, green}
    localparam logic [2:0] c_LIGHTS_RED       = 3'b100;
    localparam logic [2:0] c_LIGHTS_RED_AMBER = 3'b110;
    localparam logic [2:0] c_LIGHTS_GREEN     = 3'b001;
    localparam logic [2:0] c_LIGHTS_AMBER     = 3'b010;

    function automatic int timer_width(input int max_dwell);
        int w;
        w = $clog2(max_dwell + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_fsm.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_fsm
// Description : Four-phase traffic-light controller with per-phase dwell counts.
//               Optional macro TL_PED_REQUEST_EN holds GREEN until req is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_fsm
    import dice_lights_pkg::*;
#(
    parameter int RED_CYCLES       = 4,
    parameter int RED_AMBER_CYCLES = 1,
    parameter int GREEN_CYCLES     = 4,
    parameter int AMBER_CYCLES     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    output logic [2:0] lights
);

    localparam int c_MAX_A     = (RED_CYCLES > RED_AMBER_CYCLES) ? RED_CYCLES : RED_AMBER_CYCLES;
    localparam int c_MAX_B     = (GREEN_CYCLES > AMBER_CYCLES) ? GREEN_CYCLES : AMBER_CYCLES;
    localparam int c_MAX_DWELL = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_TIMER_W   = timer_width(c_MAX_DWELL);

    localparam logic [c_TIMER_W-1:0] c_RED_LAST       = c_TIMER_W'(RED_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_RED_AMBER_LAST = c_TIMER_W'(RED_AMBER_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_GREEN_LAST     = c_TIMER_W'(GREEN_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_AMBER_LAST     = c_TIMER_W'(AMBER_CYCLES - 1);

    light_state_e           r_state;
    light_state_e           w_state_nxt;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_TIMER_W-1:0]   w_timer_nxt;
    logic [c_TIMER_W-1:0]   w_last;

`ifndef TL_PED_REQUEST_EN
    logic w_unused_req;
    assign w_unused_req = req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RED;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + 1'b1;
        w_last      = c_RED_LAST;
        lights      = c_LIGHTS_RED;

        case (r_state)
            ST_RED: begin
                w_last = c_RED_LAST;
                lights = c_LIGHTS_RED;
            end
            ST_RED_AMBER: begin
                w_last = c_RED_AMBER_LAST;
                lights = c_LIGHTS_RED_AMBER;
            end
            ST_GREEN: begin
                w_last = c_GREEN_LAST;
                lights = c_LIGHTS_GREEN;
            end
            ST_AMBER: begin
                w_last = c_AMBER_LAST;
                lights = c_LIGHTS_AMBER;
            end
            default: begin
                w_last = c_RED_LAST;
                lights = c_LIGHTS_RED;
            end
        endcase

        if (r_timer == w_last) begin
            w_timer_nxt = '0;
            case (r_state)
                ST_RED:       w_state_nxt = ST_RED_AMBER;
                ST_RED_AMBER: w_state_nxt = ST_GREEN;
                ST_GREEN:     w_state_nxt = ST_AMBER;
                ST_AMBER:     w_state_nxt = ST_RED;
                default:      w_state_nxt = ST_RED;
            endcase
`ifdef TL_PED_REQUEST_EN
            // Expired GREEN parks with a saturated timer until a request arrives
            if ((r_state == ST_GREEN) && !req) begin
                w_state_nxt = r_state;
                w_timer_nxt = r_timer;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/dice_or_lights_gen.sv
`default_nettype none
// ============================================================================
// Module      : dice_or_lights_gen
// Description : N-faced die and traffic-light controller running concurrently;
//               sel picks which one drives result. Optional macro:
//               TL_PED_REQUEST_EN (button doubles as pedestrian request).
// Revision    : 1.0 - initial release
// ============================================================================
module dice_or_lights_gen
    import dice_lights_pkg::*;
#(
    parameter int DICE_FACES       = 6,
    parameter int W                = 3,
    parameter int RED_CYCLES       = 4,
    parameter int RED_AMBER_CYCLES = 1,
    parameter int GREEN_CYCLES     = 4,
    parameter int AMBER_CYCLES     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         button,
    input  logic         sel,
    output logic [W-1:0] result
);

    localparam logic [W-1:0] c_DIE_MAX = W'(DICE_FACES);

    logic [W-1:0] r_die;
    logic [2:0]   w_lights;
    logic [W-1:0] w_lights_ext;

    // 0 only exists after reset; the first press lands on 1 via the increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_die <= '0;
        end else if (button) begin
            r_die <= (r_die == c_DIE_MAX) ? W'(1) : r_die + 1'b1;
        end
    end

    traffic_light_fsm #(
        .RED_CYCLES       (RED_CYCLES),
        .RED_AMBER_CYCLES (RED_AMBER_CYCLES),
        .GREEN_CYCLES     (GREEN_CYCLES),
        .AMBER_CYCLES     (AMBER_CYCLES)
    ) u_traffic_light_fsm (
        .clk    (clk),
        .rst    (rst),
        .req    (button),
        .lights (w_lights)
    );

    generate
        if (W > 3) begin : g_wide_result
            assign w_lights_ext = {{(W-3){1'b0}}, w_lights};
        end else begin : g_narrow_result
            assign w_lights_ext = w_lights;
        end
    endgenerate

    assign result = sel ? w_lights_ext : r_die;

endmodule
`default_nettype wire

// File: tb/tb_dice_or_lights_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_dice_or_lights_gen
// Description : Self-checking bench for dice_or_lights_gen (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dice_or_lights_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic       sel;
    logic [2:0] result;

    int checks = 0;
    int errors = 0;

    // Reference model state: die value, light phase index and dwell count
    int m_die = 0;
    int m_ph  = 0;
    int m_tm  = 0;
    int dwell [4] = '{4, 1, 4, 1};
    int enc   [4] = '{4, 6, 1, 2};

    typedef struct {
        logic       rst;
        logic       button;
        logic       sel;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    dice_or_lights_gen dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .sel    (sel),
        .result (result)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic b, input logic s);
        rst    = r;
        button = b;
        sel    = s;
        @(posedge clk);
        if (r) begin
            m_die = 0;
            m_ph  = 0;
            m_tm  = 0;
        end else begin
            if (b) m_die = (m_die == 6) ? 1 : m_die + 1;
            if (m_tm == dwell[m_ph] - 1) begin
`ifdef TL_PED_REQUEST_EN
                if (!(m_ph == 2 && !b)) begin
                    m_ph = (m_ph + 1) % 4;
                    m_tm = 0;
                end
`else
                m_ph = (m_ph + 1) % 4;
                m_tm = 0;
`endif
            end else begin
                m_tm++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        button = 1'b0;
        sel    = 1'b0;

        // Reset, roll with wrap, then hold and resume
        tbl.push_back('{1'b1, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 3'd4});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd2});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd3});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd4});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd5});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd6});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd2});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd3});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd4});
        for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 1'b0, 1'b0, 3'd4});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd5});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].button, tbl[i].sel);
            check($sformatf("vec%0d", i), result, tbl[i].exp);
        end

        // Light timing over three periods from reset
        step(1'b1, 1'b0, 1'b1);
        check("lights_reset", result, 4);
        for (int n = 0; n < 30; n++) begin
            step(1'b0, 1'b0, 1'b1);
            check($sformatf("lights_cyc%0d", n), result, enc[m_ph]);
        end

        // Die keeps rolling while lights are displayed
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("die_pre_concurrent", result, 2);
        for (int n = 0; n < 7; n++) begin
            step(1'b0, 1'b1, 1'b1);
            check($sformatf("concurrent_lights%0d", n), result, enc[m_ph]);
        end
        button = 1'b0;
        sel    = 1'b0;
        #1;
        check("die_after_concurrent", result, 3);
        check("die_model_concurrent", result, m_die);

        // Reset while GREEN with die=3
        step(1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("green_before_reset", result, 1);
        sel = 1'b0;
        #1;
        check("die3_before_reset", result, 3);
        step(1'b1, 1'b0, 1'b1);
        check("lights_mid_reset", result, 4);
        sel = 1'b0;
        #1;
        check("die_mid_reset", result, 0);
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b0, 1'b1);
            check($sformatf("red_full_dwell%0d", n), result, 4);
        end
        step(1'b0, 1'b0, 1'b1);
        check("red_amber_after_reset", result, 6);

`ifdef TL_PED_REQUEST_EN
        // GREEN parks without a request; a one-cycle pulse releases it
        step(1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 25; n++) begin
            step(1'b0, 1'b0, 1'b1);
            check($sformatf("ped_green_hold%0d", n), result, 1);
        end
        step(1'b0, 1'b1, 1'b1);
        check("ped_amber", result, 2);
        step(1'b0, 1'b0, 1'b1);
        check("ped_red", result, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dice_or_lights_gen.md
Name: dice_or_lights_gen

Overview:
- Parametrised successor of the single-die / fixed traffic-light selector block.
- Contains two engines that run concurrently:
  - an N-faced electronic die, advanced by `button`;
  - a four-phase traffic-light controller with per-phase dwell counts.
- `sel` chooses which engine drives `result`.
- Used as the dice/lights output stage feeding LED/display logic. Same clk/rst/button/sel/result interface family as its predecessor.

Parameters:
- DICE_FACES, 6: number of die faces; legal range 2..(2**W)-1.
- W, 3: width of `result`; must be >= 3.
- RED_CYCLES, 4: clock cycles spent in RED; must be >= 1.
- RED_AMBER_CYCLES, 1: clock cycles spent in RED_AMBER; must be >= 1.
- GREEN_CYCLES, 4: clock cycles spent in GREEN; must be >= 1.
- AMBER_CYCLES, 1: clock cycles spent in AMBER; must be >= 1.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- button, input, 1: die roll enable (level-sensitive); also the pedestrian request when the optional feature is enabled.
- sel, input, 1: 0 = `result` shows the die value, 1 = `result` shows the traffic lights.
- result, output, W: selected engine output.

Behaviour:
- Reset:
  - rst is sampled on posedge clk only.
  - While rst=1: die value = 0, light state = RED, dwell timer = 0.
  - result reads 0 (sel=0) or 3'b100 zero-extended (sel=1).
- Die engine:
  - On each edge with rst=0 and button=1: value 0 -> 1, k -> k+1 for 1 <= k < DICE_FACES, DICE_FACES -> 1 (wrap).
  - button=0: value holds.
  - Value 0 occurs only between reset and the first press; it is never re-entered.
- Light engine:
  - Free-runs regardless of sel and button (base build).
  - Sequence: RED -> RED_AMBER -> GREEN -> AMBER -> RED.
  - Encoding {red,amber,green} in bits [2:0], upper bits 0: RED=100, RED_AMBER=110, GREEN=001, AMBER=010.
  - Dwell timer counts 0..X_CYCLES-1 in the current state. On reaching X_CYCLES-1 the state advances on the next edge and the timer clears.
  - A phase with dwell 1 lasts exactly one cycle.
  - Timer width = $clog2(max dwell + 1).
- Output:
  - result = sel ? lights : die.
  - Purely combinational from registered state, so a sel change is visible in the same cycle (zero latency).
  - Both engines keep updating while deselected; switching sel shows the engine's current value, not a frozen one.
- Simultaneous events: rst=1 overrides button and any dwell expiry in the same cycle.
- Reset mid-operation: both engines return to their reset values on the next edge. Light timing restarts from RED with the full RED dwell.
- No X on result after the first reset edge. All registers have reset values.

Optional Feature:
- Macro: TL_PED_REQUEST_EN.
- Defined:
  - On GREEN dwell expiry, the controller stays in GREEN (timer saturated) until button=1 is sampled, then moves to AMBER on the next edge.
  - A request already high at expiry advances immediately.
  - Dice behaviour is unchanged; button still rolls the die.
- Undefined: GREEN advances unconditionally after GREEN_CYCLES.

Decomposition:
- Package dice_lights_pkg holds:
  - the light state enum (RED, RED_AMBER, GREEN, AMBER);
  - the 3-bit light encoding constants;
  - a helper function for timer width.
- One sub-module, traffic_light_fsm:
  - owns the state register, dwell timer and TL_PED_REQUEST_EN logic;
  - ports: clk, rst, req, lights[2:0].
- The die counter and output mux stay in the top-level module.

Test Plan:
1. Reset then roll: rst=1 for 2 cycles, then rst=0, sel=0, button=1 for 8 cycles -> result 0,1,2,3,4,5,6,1,2 (wrap after 6).
2. Hold: after result=4, drop button for 5 cycles -> result stays 4; re-assert -> 5 on the next edge.
3. Light timing: default params, sel=1, after reset -> 100 x4, 110 x1, 001 x4, 010 x1, then 100 again (10-cycle period, checked over 3 periods).
4. Concurrent running: sel=1 for 7 cycles with button=1, then sel=0 -> result equals the die value advanced 7 times (not frozen).
5. Mid-operation reset: rst=1 while in GREEN with die=3 -> next edge gives die=0 and lights=100, and RED lasts a full 4 cycles.
6. With TL_PED_REQUEST_EN defined, button=0 throughout -> GREEN held 20+ cycles. Pulse button for 1 cycle -> AMBER on the following edge, then RED.
